// File: rtl/riscblade_mem_pkg.sv
// Shared memory-port constants and block-copy FSM encoding.
// Used by mem_copy_engine and mem_copy_range_chk.
package riscblade_mem_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_DEPTH = 500;
  localparam int unsigned SUM_W     = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FIN  = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  // One address step in the chosen copy direction.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              desc);
    return desc ? a - ADDR_W'(1) : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_copy_range_chk.sv
// Combinational check that [base, base+len-1] lies inside [0, depth-1].
// The sum is widened by one bit so base+len cannot wrap.
module mem_copy_range_chk
  import riscblade_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] depth,
  output logic              in_range
);

  logic [SUM_W-1:0] last_addr;
  logic [SUM_W-1:0] last_legal;

  assign last_addr  = SUM_W'(base) + SUM_W'(len) - SUM_W'(1);
  assign last_legal = SUM_W'(depth) - SUM_W'(1);

  // An empty range is trivially legal; the caller treats LEN=0 separately anyway.
  assign in_range = (len == '0) || (last_addr <= last_legal);

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy/fill initiator on the data-memory port, memmove-safe on overlap.
// Build option: MEM_COPY_FILL_EN enables fill mode; otherwise every request is a copy.
module mem_copy_engine
  import riscblade_mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W-1:0] LEN,
  input  logic              FILL,
  input  logic [DATA_W-1:0] FILL_VAL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              MEMWRITE,
  input  logic [DATA_W-1:0] MEM_OUT
);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              desc;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wr_q;

  logic              fill_req;
  logic              fill_mode;
  logic              start_desc;
  logic              src_ok;
  logic              dst_ok;
  logic              req_ok;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] src_start;
  logic [ADDR_W-1:0] dst_start;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;

`ifdef MEM_COPY_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_val_q;

  assign fill_req  = FILL;
  assign fill_mode = fill_q;
`else
  logic unused_fill;

  assign fill_req    = 1'b0;
  assign fill_mode   = 1'b0;
  assign unused_fill = ^{FILL, FILL_VAL};
`endif

  // Descending only when a copy could overrun its own unread source.
  assign start_desc = !fill_req && (DST > SRC);
  assign len_m1     = LEN - ADDR_W'(1);
  assign src_start  = start_desc ? SRC + len_m1 : SRC;
  assign dst_start  = start_desc ? DST + len_m1 : DST;
  assign src_nxt    = step_addr(src_ptr, desc);
  assign dst_nxt    = step_addr(dst_ptr, desc);

  mem_copy_range_chk u_src_chk (
    .base     (SRC),
    .len      (LEN),
    .depth    (ADDR_W'(MEM_DEPTH)),
    .in_range (src_ok)
  );

  mem_copy_range_chk u_dst_chk (
    .base     (DST),
    .len      (LEN),
    .depth    (ADDR_W'(MEM_DEPTH)),
    .in_range (dst_ok)
  );

  assign req_ok = dst_ok && (fill_req || src_ok);

  // Transfer FSM; the memory address and write strobe are registered with the state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      desc    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEM_COPY_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            src_ptr <= src_start;
            dst_ptr <= dst_start;
            cnt     <= LEN;
            desc    <= start_desc;
            busy_q  <= 1'b1;
`ifdef MEM_COPY_FILL_EN
            fill_q     <= FILL;
            fill_val_q <= FILL_VAL;
`endif
            if (LEN == '0) begin
              state  <= ST_FIN;
              done_q <= 1'b1;
            end else if (!req_ok) begin
              state <= ST_FAIL;
              err_q <= 1'b1;
            end else if (fill_req) begin
              state  <= ST_WR;
              addr_q <= dst_start;
              wr_q   <= 1'b1;
            end else begin
              state  <= ST_RD;
              addr_q <= src_start;
            end
          end
        end
        ST_RD: begin
          state  <= ST_WR;
          addr_q <= dst_ptr;
          wr_q   <= 1'b1;
        end
        ST_WR: begin
          cnt     <= cnt - ADDR_W'(1);
          src_ptr <= src_nxt;
          dst_ptr <= dst_nxt;
          if (cnt == ADDR_W'(1)) begin
            state  <= ST_FIN;
            done_q <= 1'b1;
            addr_q <= '0;
            wr_q   <= 1'b0;
          end else if (fill_mode) begin
            addr_q <= dst_nxt;
          end else begin
            state  <= ST_RD;
            addr_q <= src_nxt;
            wr_q   <= 1'b0;
          end
        end
        ST_FIN, ST_FAIL: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          addr_q <= '0;
          wr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign MEM_ADDRESS = addr_q;
  // Reset gates the strobe so the memory's own clear is never overwritten.
  assign MEMWRITE    = wr_q & RST;

  // Copy data comes straight from the read issued in the preceding RD cycle.
`ifdef MEM_COPY_FILL_EN
  assign MEM_DATA = wr_q ? (fill_q ? fill_val_q : MEM_OUT) : '0;
`else
  assign MEM_DATA = wr_q ? MEM_OUT : '0;
`endif

endmodule
